// File: rtl/crash_score_keeper_pkg.sv
// Shared game status macros and helpers for crash_score_keeper.
// Optional feature: BONUS_LIFE_EN (bonus pickups add a life).
`ifndef GAME_STATUS_BIT_LEN
`define GAME_STATUS_BIT_LEN 2
`define STATUS_PAUSE  2'd0
`define STATUS_RUN    2'd1
`define STATUS_PRERUN 2'd2
`define STATUS_OVER   2'd3
`endif

package crash_score_keeper_pkg;

  localparam int INVULN_CNT_W = 8;

  // Single BCD digit increment with carry; returns {carry_out, digit}.
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d, input logic cin);
    if (!cin)
      return {1'b0, d};
    if (d >= 4'd9)
      return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/crash_score_keeper_if.sv
// Game controller <-> score keeper bundle: crash strobes and frame timing in,
// score/lives/status flags out.
interface crash_score_keeper_if #(
  parameter int SCORE_DIGITS = 4,
  parameter int LIVES_W      = 3
);
  logic                            frame_end_i;
  logic [`GAME_STATUS_BIT_LEN-1:0] game_status_i;
  logic                            crash_me_enemy_i;
  logic                            crash_enemy_bullet_i;
  logic                            crash_me_bonus_i;
  logic [4*SCORE_DIGITS-1:0]       score_o;
  logic [LIVES_W-1:0]              lives_o;
  logic                            invuln_o;
  logic                            hit_pulse_o;
  logic                            gameover_o;

  modport master (
    output frame_end_i, game_status_i, crash_me_enemy_i, crash_enemy_bullet_i, crash_me_bonus_i,
    input  score_o, lives_o, invuln_o, hit_pulse_o, gameover_o
  );

  modport slave (
    input  frame_end_i, game_status_i, crash_me_enemy_i, crash_enemy_bullet_i, crash_me_bonus_i,
    output score_o, lives_o, invuln_o, hit_pulse_o, gameover_o
  );
endinterface

// File: rtl/crash_score_keeper_bcd_sat_counter.sv
// Packed BCD up-counter with synchronous clear; holds once every digit is 9.
module bcd_sat_counter
  import crash_score_keeper_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   value
);

  logic [4*DIGITS-1:0] nxt;
  logic                all_nines;

  always_comb begin
    logic       c;
    logic [4:0] r;
    nxt       = value;
    all_nines = 1'b1;
    c         = 1'b1;
    r         = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r              = bcd_digit_inc(value[4*i +: 4], c);
      nxt[4*i +: 4]  = r[3:0];
      c              = r[4];
      if (value[4*i +: 4] != 4'd9)
        all_nines = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr)
      value <= '0;
    else if (inc && !all_nines)
      value <= nxt;
  end

endmodule

// File: rtl/crash_score_keeper.sv
// Turns per-pixel crash strobes into per-frame score/lives events.
// Define BONUS_LIFE_EN to let bonus pickups add a life each frame.
module crash_score_keeper
  import crash_score_keeper_pkg::*;
#(
  parameter int SCORE_DIGITS  = 4,
  parameter int LIVES_W       = 3,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 60
) (
  input logic                  clk_vga,
  input logic                  rst,
  crash_score_keeper_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_INVULN = 2'd2,
    S_DEAD   = 2'd3
  } state_t;

  localparam logic [LIVES_W-1:0]      LIVES_MAX  = '1;
  localparam logic [LIVES_W-1:0]      LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [INVULN_CNT_W-1:0] INV_LOAD   = INVULN_CNT_W'(INVULN_FRAMES);

  state_t                  state;
  logic                    kill_f, hit_f;
  logic [LIVES_W-1:0]      lives, lives_b;
  logic [INVULN_CNT_W-1:0] inv_cnt;
  logic                    hit_pulse;
  logic [4*SCORE_DIGITS-1:0] score;
  logic                    is_run, is_pause, is_prerun, commit, score_inc;

  assign is_run    = (bus.game_status_i == `STATUS_RUN);
  assign is_pause  = (bus.game_status_i == `STATUS_PAUSE);
  assign is_prerun = (bus.game_status_i == `STATUS_PRERUN);
  assign commit    = bus.frame_end_i && !is_pause && !is_prerun;
  assign score_inc = commit && kill_f && (state == S_PLAY || state == S_INVULN);

  // Flags clear on frame_end, then a coincident crash opens the next frame's flag.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      kill_f <= 1'b0;
      hit_f  <= 1'b0;
    end else if (bus.frame_end_i) begin
      kill_f <= is_run && bus.crash_enemy_bullet_i;
      hit_f  <= is_run && bus.crash_me_enemy_i;
    end else if (is_run) begin
      kill_f <= kill_f || bus.crash_enemy_bullet_i;
      hit_f  <= hit_f  || bus.crash_me_enemy_i;
    end
  end

`ifdef BONUS_LIFE_EN
  logic bonus_f;

  always_ff @(posedge clk_vga) begin
    if (rst)
      bonus_f <= 1'b0;
    else if (bus.frame_end_i)
      bonus_f <= is_run && bus.crash_me_bonus_i;
    else if (is_run)
      bonus_f <= bonus_f || bus.crash_me_bonus_i;
  end

  // Bonus lands before the hit decrement so bonus+hit in one frame nets zero.
  assign lives_b = (bonus_f && lives != LIVES_MAX) ? lives + 1'b1 : lives;
`else
  logic unused_bonus;
  assign unused_bonus = bus.crash_me_bonus_i;
  assign lives_b      = lives;
`endif

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state     <= S_IDLE;
      lives     <= LIVES_LOAD;
      inv_cnt   <= '0;
      hit_pulse <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      if (is_prerun) begin
        state <= S_IDLE;
        lives <= LIVES_LOAD;
      end else begin
        case (state)
          S_IDLE:
            if (is_run)
              state <= S_PLAY;
          S_PLAY:
            if (commit) begin
              if (hit_f && lives_b != '0) begin
                lives     <= lives_b - 1'b1;
                hit_pulse <= 1'b1;
                if (lives_b == LIVES_W'(1)) begin
                  state <= S_DEAD;
                end else begin
                  inv_cnt <= INV_LOAD;
                  state   <= S_INVULN;
                end
              end else begin
                lives <= lives_b;
              end
            end
          S_INVULN:
            if (commit) begin
              lives   <= lives_b;
              inv_cnt <= inv_cnt - 1'b1;
              if (inv_cnt == INVULN_CNT_W'(1))
                state <= S_PLAY;
            end
          S_DEAD: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  bcd_sat_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .clk   (clk_vga),
    .rst   (rst),
    .clr   (is_prerun),
    .inc   (score_inc),
    .value (score)
  );

  assign bus.score_o     = score;
  assign bus.lives_o     = lives;
  assign bus.invuln_o    = (state == S_INVULN);
  assign bus.hit_pulse_o = hit_pulse;
  assign bus.gameover_o  = (state == S_DEAD);

endmodule
